mem_responder: RTL

Memory-side responder for the CPU's MAR/MDR bus interface. Samples the datapath's read/write strobes, address (MAR) and write data (MDR). Performs the access on an internal word-addressed synchronous RAM after a programmable number of wait states, returns read data for MDR capture, and signals completion with a level handshake. It replaces the zero-latency RAM so the control unit can be exercised with real memory latency.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and default constants for the MAR/MDR memory responder.
// The optional write-protect build is selected with MEM_WRITE_PROTECT_EN.
package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_PROT_TOP    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  // An address is usable only when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] a, input int aw);
    return ((a >> aw) == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word-addressed synchronous RAM with a registered read port.
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Read-before-write array port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the MAR/MDR bus: programmable wait states, level handshake.
// Define MEM_WRITE_PROTECT_EN to block writes below PROT_TOP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int PROT_TOP    = DEF_PROT_TOP
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              in_range_s;
  logic              prot_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_dout_s;

  assign in_range_s = addr_in_range(addr_q, ADDR_W);

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_s = (addr_q < 32'(PROT_TOP));
`else
  assign prot_s = 1'b0;
`endif

  // The array is read on the edge that enters ACCESS, so with no wait states the
  // live bus address must be used because it has not been latched yet.
  assign mem_addr_s = (state_q == IDLE) ? addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clock (clock),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .din   (wdata_q),
    .dout  (mem_dout_s)
  );

  // Next-state, request latching and access decisions.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (read && write) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (read ^ write) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = write ? OP_WR : OP_RD;
          err_d   = 1'b0;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!in_range_s) begin
          err_d = 1'b1;
          if (op_q == OP_RD) begin
            rdata_d = {DATA_W{1'b0}};
          end else begin
            rdata_d = rdata_q;
          end
        end else if (op_q == OP_RD) begin
          rdata_d = mem_dout_s;
        end else if (prot_s) begin
          err_d = 1'b1;
        end else begin
          mem_we_s = 1'b1;
        end
      end
      DONE: begin
        if (!read && !write) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == DONE);
    busy_d  = (state_d == WAIT) || (state_d == ACCESS);
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 4'd0;
      addr_q  <= {DATA_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
